// File: rtl/fetch_align.sv
// Instruction fetch and RV32IC realignment stage: word fetch into a halfword queue,
// one instruction per cycle into the IF/ID register, static BTFN prediction.
module fetch_align #(
    parameter logic [31:0] BOOT_ADDR = 32'h8000_0000,
    parameter int          QDEPTH    = 4
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        stallF_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pcF_o,
    output logic [31:0] instrF_o,
    output logic        tb_update_o,
    output logic        bTakenF_o
);
    localparam int          QW  = $clog2(QDEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [15:0]   q [QDEPTH];
    logic [QW-1:0] rd_ptr, wr_ptr;
    logic [QW:0]   count;
    logic [31:0]   fpc, ipc;
    logic          req_q, outstanding, discard, req_half;

    logic [15:0]   h0, h1;
    logic [31:0]   instr, imm, target;
    logic          need2, avail, issue, taken, flush, granted, push;
    logic          is_jal, is_br;
    logic [1:0]    npop, npush;
    logic [QW:0]   count_next;
    logic          out_next, discard_next, req_next;

    always_comb begin
        h0     = q[rd_ptr];
        h1     = q[rd_ptr + QW'(1)];
        need2  = (h0[1:0] == 2'b11);
        avail  = need2 ? (count > (QW+1)'(1)) : (count != '0);
        issue  = avail && !stallF_i && !redirect_i;
        instr  = need2 ? {h1, h0} : {16'h0000, h0};
        is_jal = (instr[6:0] == 7'b1101111);
        is_br  = (instr[6:0] == 7'b1100011);
        taken  = issue && need2 && (is_jal || (is_br && instr[31]));
        imm    = is_jal ? {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0}
                        : {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
        target = ipc + imm;
        flush  = redirect_i || taken;

        granted = req_q && imem_gnt_i;
        // Responses to a flushed request, or arriving in a flush cycle, belong to the old path.
        push    = imem_rvalid_i && outstanding && !discard && !flush;
        npush   = !push ? 2'd0 : (req_half ? 2'd1 : 2'd2);
        npop    = !issue ? 2'd0 : (need2 ? 2'd2 : 2'd1);
        count_next = count + (QW+1)'(npush) - (QW+1)'(npop);

        out_next     = granted || (outstanding && !imem_rvalid_i);
        discard_next = 1'b0;
        req_next     = 1'b0;
        if (flush) begin
            discard_next = out_next;
            req_next     = !out_next;
        end else begin
            discard_next = discard && out_next;
            if (req_q && !imem_gnt_i)
                req_next = 1'b1;
            else
                req_next = !out_next && (count_next <= (QW+1)'(QDEPTH - 2));
        end
    end

    assign imem_req_o  = req_q;
    assign imem_addr_o = {fpc[31:2], 2'b00};

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            req_q       <= 1'b0;
            outstanding <= 1'b0;
            discard     <= 1'b0;
            req_half    <= 1'b0;
            fpc         <= BOOT_ADDR;
            ipc         <= BOOT_ADDR;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            pcF_o       <= BOOT_ADDR;
            instrF_o    <= NOP;
            tb_update_o <= 1'b0;
            bTakenF_o   <= 1'b0;
        end else begin
            req_q       <= req_next;
            outstanding <= out_next;
            discard     <= discard_next;
            if (granted)
                req_half <= fpc[1];

            if (redirect_i) begin
                fpc <= redirect_pc_i & 32'hFFFF_FFFE;
                ipc <= redirect_pc_i & 32'hFFFF_FFFE;
            end else if (taken) begin
                fpc <= target;
                ipc <= target;
            end else begin
                if (granted)
                    fpc <= (fpc & 32'hFFFF_FFFC) + 32'd4;
                if (issue)
                    ipc <= ipc + (need2 ? 32'd4 : 32'd2);
            end

            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                rd_ptr <= rd_ptr + QW'(npop);
                wr_ptr <= wr_ptr + QW'(npush);
                count  <= count_next;
            end

            // IF/ID register: redirect forces a bubble even under stall; pcF holds on bubbles.
            if (redirect_i) begin
                instrF_o    <= NOP;
                tb_update_o <= 1'b0;
                bTakenF_o   <= 1'b0;
            end else if (!stallF_i) begin
                if (issue) begin
                    pcF_o       <= ipc;
                    instrF_o    <= instr;
                    tb_update_o <= 1'b1;
                    bTakenF_o   <= taken;
                end else begin
                    instrF_o    <= NOP;
                    tb_update_o <= 1'b0;
                    bTakenF_o   <= 1'b0;
                end
            end
        end
    end

    // First word after a halfword-aligned target only contributes its upper half.
    always_ff @(posedge clk_i) begin
        if (push) begin
            if (req_half) begin
                q[wr_ptr] <= imem_rdata_i[31:16];
            end else begin
                q[wr_ptr]          <= imem_rdata_i[15:0];
                q[wr_ptr + QW'(1)] <= imem_rdata_i[31:16];
            end
        end
    end
endmodule

// File: tb/tb_fetch_align.sv
// Bench for fetch_align: random memory latency, stalls and redirects against an
// architectural next-PC model of the instruction stream.
module tb_fetch_align;
    localparam logic [31:0] BOOT = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, redirect;
    logic [31:0] rpc;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] pcF, instrF;
    logic        tb_update, bTaken;

    fetch_align #(.BOOT_ADDR(BOOT), .QDEPTH(4)) dut (
        .clk_i(clk), .rstn_i(rst_n), .stallF_i(stall), .redirect_i(redirect),
        .redirect_pc_i(rpc), .imem_req_o(imem_req), .imem_addr_o(imem_addr),
        .imem_gnt_i(imem_gnt), .imem_rvalid_i(imem_rvalid), .imem_rdata_i(imem_rdata),
        .pcF_o(pcF), .instrF_o(instrF), .tb_update_o(tb_update), .bTakenF_o(bTaken)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        logic        bt;
    } lit_t;

    logic [15:0] mem [1024];
    lit_t        lit_q[$];
    int          total = 0, bad = 0, issued = 0;
    logic        pending = 1'b0;
    int          cnt = 0;
    logic [31:0] paddr;
    logic        rst_pulse = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h want %08h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] hw(input logic [31:0] a);
        return mem[a[10:1]];
    endfunction

    // Memory responder: random grant, response 1..3 cycles after the grant cycle.
    initial begin
        logic        g;
        logic [31:0] ga;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        forever begin
            @(negedge clk);
            g  = imem_req && imem_gnt;
            ga = imem_addr;
            @(posedge clk); #1;
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
            if (g) begin
                pending = 1'b1;
                cnt     = $urandom_range(0, 2);
                paddr   = ga;
            end
            if (pending) begin
                if (cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = {mem[{paddr[10:2], 1'b1}], mem[{paddr[10:2], 1'b0}]};
                    pending     = 1'b0;
                end else begin
                    cnt--;
                end
            end
            imem_gnt = ($urandom_range(0, 3) != 0);
        end
    end

    // Compare process: expected stream follows program order with BTFN on 32-bit instrs.
    initial begin
        logic [31:0] mpc, ppc, pins, ei, off, nxt;
        logic [15:0] h;
        logic        ptb, pbt, ps, pr, et;
        mpc = BOOT; ppc = BOOT; pins = 32'h13; ptb = 0; pbt = 0; ps = 0; pr = 0;
        forever begin
            @(negedge clk);
            if (!rst_n || rst_pulse) begin
                chk("reset_pc", pcF, BOOT);
                chk("reset_instr", instrF, 32'h13);
                chk("reset_tbu", {31'b0, tb_update}, 32'd0);
                chk("reset_bt", {31'b0, bTaken}, 32'd0);
                chk("reset_req", {31'b0, imem_req}, 32'd0);
                mpc = BOOT; ps = 0; pr = 0; rst_pulse = 1'b0;
            end else begin
                if (pr || (!ps && !tb_update)) begin
                    chk("bubble_tbu", {31'b0, tb_update}, 32'd0);
                    chk("bubble_instr", instrF, 32'h13);
                    chk("bubble_bt", {31'b0, bTaken}, 32'd0);
                    chk("bubble_pc_hold", pcF, ppc);
                end else if (ps) begin
                    chk("stall_pc", pcF, ppc);
                    chk("stall_instr", instrF, pins);
                    chk("stall_tbu", {31'b0, tb_update}, {31'b0, ptb});
                    chk("stall_bt", {31'b0, bTaken}, {31'b0, pbt});
                end else begin
                    h = hw(mpc);
                    if (h[1:0] == 2'b11) ei = {hw(mpc + 32'd2), h};
                    else                 ei = {16'h0, h};
                    et = (h[1:0] == 2'b11) &&
                         (ei[6:0] == 7'h6F || (ei[6:0] == 7'h63 && ei[31]));
                    if (ei[6:0] == 7'h6F)
                        off = {{12{ei[31]}}, ei[19:12], ei[20], ei[30:21], 1'b0};
                    else
                        off = {{20{ei[31]}}, ei[7], ei[30:25], ei[11:8], 1'b0};
                    nxt = et ? mpc + off : mpc + ((h[1:0] == 2'b11) ? 32'd4 : 32'd2);
                    chk("model_pc", pcF, mpc);
                    chk("model_instr", instrF, ei);
                    chk("model_bt", {31'b0, bTaken}, {31'b0, et});
                    if (lit_q.size() > 0) begin
                        chk("lit_pc", pcF, lit_q[0].pc);
                        chk("lit_instr", instrF, lit_q[0].ins);
                        chk("lit_bt", {31'b0, bTaken}, {31'b0, lit_q[0].bt});
                        void'(lit_q.pop_front());
                    end
                    mpc = nxt;
                    issued++;
                end
                if (pending)
                    chk("single_outstanding", {31'b0, imem_req}, 32'd0);
                if (redirect)
                    mpc = rpc & 32'hFFFF_FFFE;
                ps = stall; pr = redirect;
            end
            ppc = pcF; pins = instrF; ptb = tb_update; pbt = bTaken;
        end
    end

    task automatic push_lit(input logic [31:0] pc, input logic [31:0] ins, input logic bt);
        lit_t l;
        l.pc = pc; l.ins = ins; l.bt = bt;
        lit_q.push_back(l);
    endtask

    task automatic wait_lit(input int lim, input string nm);
        for (int i = 0; i < lim && lit_q.size() > 0; i++) @(posedge clk);
        if (lit_q.size() > 0) begin
            total++; bad++;
            $display("FAIL %s: %0d expected instrs never issued, want 0 left", nm, lit_q.size());
            lit_q.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic random_run(input int cycles);
        int srun;
        srun = 0;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk); #1;
            redirect = 1'b0;
            if (srun == 0 && $urandom_range(0, 7) == 0) srun = $urandom_range(1, 4);
            stall = (srun > 0);
            if (srun > 0) srun--;
            if ($urandom_range(0, 29) == 0 || (pending && $urandom_range(0, 9) == 0)) begin
                redirect = 1'b1;
                rpc = BOOT | (32'($urandom_range(0, 1023)) << 1) | 32'($urandom_range(0, 1));
            end
        end
        @(posedge clk); #1;
        redirect = 1'b0; stall = 1'b0;
    endtask

    initial begin
        bit found;
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; rpc = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
        // 0x00: addi x1,x0,5 | 0x04: c.li, c.nop | 0x08,0x0C: nop | 0x10: bne x0,x0,-8
        mem[0] = 16'h0093; mem[1] = 16'h0050;
        mem[2] = 16'h4501; mem[3] = 16'h0001;
        mem[4] = 16'h0013; mem[5] = 16'h0000;
        mem[6] = 16'h0013; mem[7] = 16'h0000;
        mem[8] = 16'h1CE3; mem[9] = 16'hFE00;
        // addi straddling the words at 0x100/0x104, entered at 0x102
        mem[8'h81] = 16'h0093; mem[8'h82] = 16'h0050;

        push_lit(32'h8000_0000, 32'h0050_0093, 1'b0);
        push_lit(32'h8000_0004, 32'h0000_4501, 1'b0);
        push_lit(32'h8000_0006, 32'h0000_0001, 1'b0);
        push_lit(32'h8000_0008, 32'h0000_0013, 1'b0);
        push_lit(32'h8000_000C, 32'h0000_0013, 1'b0);
        push_lit(32'h8000_0010, 32'hFE00_1CE3, 1'b1);
        push_lit(32'h8000_0008, 32'h0000_0013, 1'b0);

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_lit(300, "boot_stream");

        redirect = 1'b1; rpc = 32'h8000_0102;
        @(posedge clk); #1;
        redirect = 1'b0;
        push_lit(32'h8000_0102, 32'h0050_0093, 1'b0);
        wait_lit(300, "straddle");

        random_run(3000);

        // Async reset while a granted response is due next cycle: that response must be ignored.
        found = 1'b0;
        for (int i = 0; i < 500 && !found; i++) begin
            @(posedge clk); #2;
            if (pending && cnt == 0) found = 1'b1;
        end
        if (found) begin
            rst_pulse = 1'b1;
            rst_n = 1'b0;
            #1 rst_n = 1'b1;
        end else begin
            total++; bad++;
            $display("FAIL midreset_setup: no in-flight response found, want one within 500 cycles");
        end

        random_run(1000);

        total++;
        if (issued < 300) begin
            bad++;
            $display("FAIL liveness: issued %0d want >= 300", issued);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
